// File: rtl/msi_irq_scheduler.sv
// Round-robin MSI scheduler: latches interrupt requests as pending flags and
// issues them one at a time to the PCIe core, with retry backoff and timeout.
`timescale 1ns/1ps
module msi_irq_scheduler #(
    parameter int NUM_VEC     = 8,
    parameter int RETRY_DELAY = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_VEC-1:0] irq_req,
    output logic [NUM_VEC-1:0] irq_pending,
    input  logic [3:0]         cfg_interrupt_msi_enable,
    input  logic [11:0]        cfg_interrupt_msi_mmenable,
    output logic [31:0]        cfg_interrupt_msi_int,
    input  logic               cfg_interrupt_msi_sent,
    input  logic               cfg_interrupt_msi_fail,
    output logic [15:0]        irq_sent_count,
    output logic               irq_timeout
);

    localparam int CNT_MAX = (TIMEOUT > RETRY_DELAY) ? TIMEOUT : RETRY_DELAY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        BACKOFF = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         rst_sync_q;
    logic [NUM_VEC-1:0] pending_q, pending_d;
    logic [NUM_VEC-1:0] clr_mask;
    logic [4:0]         vec_q, vec_d;
    logic [4:0]         last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [31:0]        msi_q, msi_d;
    logic [15:0]        count_q, count_d;
    logic               timeout_pulse;
    logic               run;

    logic               hi_found, lo_found, grant_valid;
    logic [4:0]         hi_idx, lo_idx, grant, fold_mask, fold_vec;
    logic               unused_cfg;

    assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};
    assign run = rst_sync_q[1];

    // Reset release ripples through two flops before the scheduler may act.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    // Round robin: lowest pending index above last_q wins, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                if (5'(i) > last_q) begin
                    hi_found = 1'b1;
                    hi_idx   = 5'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = 5'(i);
                end
            end
        end
        grant_valid = hi_found | lo_found;
        grant       = hi_found ? hi_idx : lo_idx;
        for (int b = 0; b < 5; b++) begin
            fold_mask[b] = (cfg_interrupt_msi_mmenable[2:0] > 3'(b));
        end
        fold_vec = grant & fold_mask;
    end

    // Handshake: cfg_interrupt_msi_int is a single-cycle one-hot request; the
    // core answers with exactly one of sent/fail (fail dominates), any time later.
    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        count_d       = count_q;
        msi_d         = '0;
        timeout_pulse = 1'b0;
        clr_mask      = '0;
        if (run) begin
            case (state_q)
                IDLE: begin
                    if (cfg_interrupt_msi_enable[0] && grant_valid) begin
                        state_d = WAIT;
                        vec_d   = grant;
                        cnt_d   = CW'(1);
                        msi_d   = 32'd1 << fold_vec;
                    end
                end
                WAIT: begin
                    if (cfg_interrupt_msi_fail) begin
                        last_d  = vec_q;
                        state_d = BACKOFF;
                        cnt_d   = CW'(RETRY_DELAY);
                    end else if (cfg_interrupt_msi_sent) begin
                        for (int i = 0; i < NUM_VEC; i++) begin
                            clr_mask[i] = (vec_q == 5'(i));
                        end
                        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                        last_d  = vec_q;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        timeout_pulse = 1'b1;
                        last_d        = vec_q;
                        state_d       = IDLE;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                BACKOFF: begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                default: state_d = IDLE;
            endcase
        end
        // A new request in the same cycle as the clear keeps the bit set.
        pending_d = run ? ((pending_q & ~clr_mask) | irq_req) : pending_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            vec_q     <= '0;
            last_q    <= 5'(NUM_VEC - 1);
            cnt_q     <= '0;
            msi_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            vec_q     <= vec_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            msi_q     <= msi_d;
            count_q   <= count_d;
        end
    end

    assign irq_pending           = pending_q;
    assign cfg_interrupt_msi_int = msi_q;
    assign irq_sent_count        = count_q;
    assign irq_timeout           = timeout_pulse;

endmodule

// File: tb/tb_msi_irq_scheduler.sv
// Directed bench for msi_irq_scheduler: reset, latency, round robin, retry,
// fold, timeout, enable gating and reset during an outstanding MSI.
`timescale 1ns/1ps
module tb_msi_irq_scheduler;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq_req;
    logic [7:0]  irq_pending;
    logic [3:0]  en;
    logic [11:0] mm;
    logic [31:0] msi_int;
    logic        sent;
    logic        fail;
    logic [15:0] sent_count;
    logic        timeout;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] any;

    msi_irq_scheduler #(.NUM_VEC(8), .RETRY_DELAY(16), .TIMEOUT(1024)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .irq_req                    (irq_req),
        .irq_pending                (irq_pending),
        .cfg_interrupt_msi_enable   (en),
        .cfg_interrupt_msi_mmenable (mm),
        .cfg_interrupt_msi_int      (msi_int),
        .cfg_interrupt_msi_sent     (sent),
        .cfg_interrupt_msi_fail     (fail),
        .irq_sent_count             (sent_count),
        .irq_timeout                (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_msi(input int bound);
        int n;
        n = 0;
        while (msi_int === 32'd0 && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0; irq_req = '0; en = '0; mm = '0; sent = 1'b0; fail = 1'b0;
        repeat (3) tick();
        chk("rst_pending", 32'(irq_pending), 32'h0);
        chk("rst_msi", msi_int, 32'h0);
        chk("rst_count", 32'(sent_count), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);

        irq_req = 8'h01; rst_n = 1'b1;
        tick();
        chk("sync_first_edge", 32'(irq_pending), 32'h0);
        irq_req = '0;
        repeat (3) tick();
        chk("sync_idle", 32'(irq_pending), 32'h0);

        // Basic issue with two-cycle latency
        en = 4'h1; mm = 12'h3;
        tick();
        irq_req = 8'h04;
        tick();
        irq_req = '0;
        chk("basic_pend", 32'(irq_pending), 32'h04);
        chk("basic_lat1", msi_int, 32'h0);
        tick();
        chk("basic_msi", msi_int, 32'h4);
        tick();
        chk("basic_pulse", msi_int, 32'h0);
        repeat (2) tick();
        sent = 1'b1;
        tick();
        sent = 1'b0;
        chk("basic_clr", 32'(irq_pending), 32'h0);
        chk("basic_cnt", 32'(sent_count), 32'd1);

        // Round robin from a fresh reset, with a re-request racing the first sent
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rr_cnt_reset", 32'(sent_count), 32'd0);
        irq_req = 8'hFF;
        tick();
        irq_req = '0;
        for (int k = 0; k < 9; k++) begin
            int exp_vec;
            exp_vec = (k == 8) ? 0 : k;
            wait_msi(20);
            chk($sformatf("rr_grant%0d", k), msi_int, 32'd1 << exp_vec);
            tick();
            chk($sformatf("rr_single%0d", k), msi_int, 32'h0);
            sent = 1'b1;
            if (k == 0) irq_req = 8'h01;
            tick();
            sent = 1'b0; irq_req = '0;
            if (k == 0) chk("rr_set_wins", 32'(irq_pending), 32'hFF);
        end
        chk("rr_pend_empty", 32'(irq_pending), 32'h0);
        chk("rr_count", 32'(sent_count), 32'd9);

        // Fail then backoff, sent+fail counts as fail, backoff arbitration
        irq_req = 8'h08;
        tick();
        irq_req = '0;
        wait_msi(20);
        chk("fail_first", msi_int, 32'h8);
        tick();
        fail = 1'b1;
        tick();
        fail = 1'b0;
        chk("fail_keep", 32'(irq_pending), 32'h08);
        any = '0;
        repeat (17) begin
            tick();
            any |= msi_int;
        end
        chk("backoff_quiet", any, 32'h0);
        tick();
        chk("retry_only", msi_int, 32'h8);
        tick();
        sent = 1'b1; fail = 1'b1;
        tick();
        sent = 1'b0; fail = 1'b0;
        chk("both_pend", 32'(irq_pending), 32'h08);
        chk("both_cnt", 32'(sent_count), 32'd9);
        irq_req = 8'h20;
        tick();
        irq_req = '0;
        wait_msi(30);
        chk("retry_rr", msi_int, 32'h20);
        tick();
        sent = 1'b1;
        tick();
        sent = 1'b0;
        chk("retry_rr_pend", 32'(irq_pending), 32'h08);
        chk("retry_rr_cnt", 32'(sent_count), 32'd10);
        wait_msi(20);
        chk("retry_last", msi_int, 32'h8);
        tick();
        sent = 1'b1;
        tick();
        sent = 1'b0;
        chk("retry_done_pend", 32'(irq_pending), 32'h0);
        chk("retry_done_cnt", 32'(sent_count), 32'd11);

        // Fold with mmenable=1, then timeout on the 1024th WAIT cycle
        mm = 12'h1;
        irq_req = 8'h40;
        tick();
        irq_req = '0;
        wait_msi(20);
        chk("fold", msi_int, 32'h1);
        repeat (1022) tick();
        chk("tmo_early", 32'(timeout), 32'h0);
        tick();
        chk("tmo_pulse", 32'(timeout), 32'h1);
        chk("tmo_msi", msi_int, 32'h0);
        en = 4'h0;
        tick();
        chk("tmo_once", 32'(timeout), 32'h0);
        chk("tmo_keep", 32'(irq_pending), 32'h40);

        // Enable off: nothing issued, pending keeps accumulating
        any = '0;
        irq_req = 8'h02;
        tick();
        irq_req = '0;
        any |= msi_int;
        repeat (8) begin
            tick();
            any |= msi_int;
        end
        chk("dis_quiet", any, 32'h0);
        chk("dis_accum", 32'(irq_pending), 32'h42);
        en = 4'h1;
        wait_msi(20);
        chk("rr_fold", msi_int, 32'h2);
        tick();
        sent = 1'b1;
        tick();
        sent = 1'b0;
        chk("pend_after", 32'(irq_pending), 32'h40);
        chk("cnt_after", 32'(sent_count), 32'd12);

        // Reset while an MSI is outstanding
        wait_msi(20);
        chk("reissue6", msi_int, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_msi", msi_int, 32'h0);
        chk("midrst_pend", 32'(irq_pending), 32'h0);
        chk("midrst_cnt", 32'(sent_count), 32'h0);
        chk("midrst_tmo", 32'(timeout), 32'h0);
        tick();
        rst_n = 1'b1;
        any = '0;
        repeat (6) begin
            tick();
            any |= msi_int;
        end
        chk("no_retry", any, 32'h0);
        chk("no_retry_pend", 32'(irq_pending), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msi_irq_scheduler.md
MSI_IRQ_SCHEDULER -- requirements
Module: msi_irq_scheduler

Interface

Parameters:
REQ-001 The block SHALL have parameter NUM_VEC, default 8, range 1..32: number of interrupt requesters/vectors.
REQ-002 The block SHALL have parameter RETRY_DELAY, default 16: idle cycles after an MSI fail before re-arbitration.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024: WAIT-state cycles before abandoning an issued MSI.

Ports:
REQ-004 The block SHALL have port clk, input, 1: PCIe user clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port irq_req, input, NUM_VEC: a 1 on bit i in any cycle sets pending[i].
REQ-007 The block SHALL have port irq_pending, output, NUM_VEC: registered pending flags.
REQ-008 The block SHALL have port cfg_interrupt_msi_enable, input, 4: only bit 0 (PF0 MSI enable) is used.
REQ-009 The block SHALL have port cfg_interrupt_msi_mmenable, input, 12: only bits [2:0] (log2 of allowed vectors) are used.
REQ-010 The block SHALL have port cfg_interrupt_msi_int, output, 32: one-hot MSI request pulse to the PCIe core.
REQ-011 The block SHALL have port cfg_interrupt_msi_sent, input, 1: one-cycle success pulse from the core.
REQ-012 The block SHALL have port cfg_interrupt_msi_fail, input, 1: one-cycle failure pulse from the core.
REQ-013 The block SHALL have port irq_sent_count, output, 16: saturating count of successful MSIs.
REQ-014 The block SHALL have port irq_timeout, output, 1: one-cycle pulse when an issued MSI times out.

Function

REQ-015 The block SHALL implement a state machine with states IDLE, WAIT and BACKOFF; it SHALL have no other states.
REQ-016 Pending set/clear:
- pending[i] SHALL be set the cycle after irq_req[i]=1.
- If a set and a clear of the same bit occur in one cycle, the set SHALL win.
REQ-017 Arbitration SHALL be round-robin:
- The search SHALL start at index last_grant+1, modulo NUM_VEC.
- last_grant SHALL reset to NUM_VEC-1, so vector 0 has first priority after reset.
REQ-018 IDLE SHALL move to WAIT only when cfg_interrupt_msi_enable[0]=1 and at least one pending bit is set.
- On that transition, vec SHALL latch the granted index.
- On that transition, cfg_interrupt_msi_int SHALL be driven for exactly one cycle.
REQ-019 The asserted cfg_interrupt_msi_int bit SHALL be vec & ((1<<mmenable[2:0])-1), folding vectors beyond the allowed count; all other bits SHALL be 0.
REQ-020 Latency: with the FSM idle and MSI enabled, cfg_interrupt_msi_int SHALL go high exactly 2 cycles after the cycle irq_req is sampled high.
REQ-021 In WAIT, when sent=1 and fail=0:
- pending[vec] SHALL be cleared.
- irq_sent_count SHALL increment, saturating at 16'hFFFF.
- last_grant SHALL be set to vec.
- The FSM SHALL go to IDLE.
REQ-022 In WAIT, when fail=1, regardless of sent:
- pending[vec] SHALL be kept.
- last_grant SHALL be set to vec.
- The FSM SHALL go to BACKOFF with its counter loaded to RETRY_DELAY.
REQ-023 In WAIT, when a cycle counter reaches TIMEOUT with no response:
- irq_timeout SHALL pulse for one cycle.
- pending[vec] SHALL be kept.
- last_grant SHALL be set to vec.
- The FSM SHALL go to IDLE.
REQ-024 BACKOFF SHALL decrement its counter each cycle and SHALL move to IDLE on the cycle the counter equals 0.
REQ-025 If MSI enable deasserts, IDLE SHALL hold and pending bits SHALL keep accumulating; WAIT and BACKOFF SHALL still complete normally.
REQ-026 sent or fail pulses received outside WAIT SHALL be ignored.
REQ-027 At most one MSI SHALL be outstanding at any time; cfg_interrupt_msi_int SHALL never be asserted outside the IDLE->WAIT transition cycle.

Reset

REQ-028 While rst_n=0, asynchronously, the block SHALL clear the following: state=IDLE, pending=0, cfg_interrupt_msi_int=0, irq_sent_count=0, irq_timeout=0, all counters=0, last_grant=NUM_VEC-1.
REQ-029 When reset is asserted mid-WAIT, the in-flight vector SHALL be discarded, with no retry after release.
REQ-030 Reset release SHALL be synchronized; the first state change SHALL occur no earlier than the second clk edge after rst_n rises.

Verification

REQ-031 Basic: enable=1, mmenable=3; irq_req=8'h04 for one cycle -> msi_int=32'h4 two cycles later for one cycle; sent 5 cycles later -> pending[2]=0, count=1.
REQ-032 Round-robin: pending=8'hFF, every MSI answered with sent -> grant order 0,1,...,7,0; exactly one MSI outstanding at a time.
REQ-033 Fail/retry: fail on vector 3 with RETRY_DELAY=16 -> no msi_int for 17 cycles, then vector 3 is reissued if it is the only pending bit; if vector 5 is also pending, vector 5 is issued first.
REQ-034 Fold/timeout: mmenable=1 with vec 6 -> msi_int=32'h1; no response with TIMEOUT=1024 -> irq_timeout pulses on the 1024th WAIT cycle and pending[6] stays 1.
REQ-035 Corner cases: irq_req[vec]=1 coincident with sent -> pending stays 1 and the vector is reissued; sent and fail together -> treated as fail; enable=0 with pending set -> no msi_int; rst_n low mid-WAIT -> all outputs 0 immediately.
